// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared definitions for the instruction-fetch sequencer.
// Contents:
//   fetchState_t   3-bit binary state encoding for the fetch FSM
//   strobes_t      bundle of datapath strobes driven during a fetch
//   NO_STROBES     all-strobes-off constant
//   decodeStrobes  maps a state, plus the stall level, onto its strobe pattern
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T0    = 3'd1,
        T1    = 3'd2,
        T2    = 3'd3,
        EXEC  = 3'd4,
        HALT  = 3'd5,
        FAULT = 3'd6
    } fetchState_t;

    typedef struct packed {
        logic pcOut;
        logic marIn;
        logic inc;
        logic read;
        logic mdrIn;
        logic mdrOut;
        logic irIn;
    } strobes_t;

    localparam strobes_t NO_STROBES = '0;

    // Strobe pattern for the cycle spent in state s. In T0 the stall level
    // gates the PC/MAR strobes, so a stalled T0 cycle moves nothing.
    function automatic strobes_t decodeStrobes(fetchState_t s, logic stall);
        strobes_t st;
        st = NO_STROBES;
        case (s)
            T0: begin
                if (!stall) begin
                    st.pcOut = 1'b1;
                    st.marIn = 1'b1;
                    st.inc   = 1'b1;
                end
            end
            T1: begin
                st.read  = 1'b1;
                st.mdrIn = 1'b1;
            end
            T2: begin
                st.mdrOut = 1'b1;
                st.irIn   = 1'b1;
            end
            default: st = NO_STROBES;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Groups the run/halt control inputs, the memory/execute handshakes and the
// datapath strobes of the fetch sequencer.
//   master : the sequencer (drives strobes, status and instr_count)
//   slave  : the surrounding control/datapath (drives run, stall, halt_req,
//            mem_ready, exec_done)
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             stall;
    logic             halt_req;
    logic             mem_ready;
    logic             exec_done;
    logic             PCout;
    logic             MARin;
    logic             Inc;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             exec_start;
    logic             halted;
    logic             mem_fault;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, stall, halt_req, mem_ready, exec_done,
        output PCout, MARin, Inc, Read, MDRin, MDRout, IRin,
        output exec_start, halted, mem_fault, instr_count
    );

    modport slave (
        output run, stall, halt_req, mem_ready, exec_done,
        input  PCout, MARin, Inc, Read, MDRin, MDRout, IRin,
        input  exec_start, halted, mem_fault, instr_count
    );
endinterface

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles spent waiting on memory.
// Ports:
//   clock   in  system clock, rising edge
//   clear   in  asynchronous active-low reset (count -> 0)
//   clr     in  synchronous clear, wins over en
//   en      in  count this cycle
//   expired out high during the MEM_TIMEOUT-th consecutive enabled cycle
// TMR_W must be wide enough to hold MEM_TIMEOUT-1; MEM_TIMEOUT >= 1.
module mem_wait_timer #(
    parameter int TMR_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(MEM_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    // The count is 0 in the first waiting cycle, so it equals LAST_COUNT in
    // the final allowed cycle; the owner leaves the wait before it can wrap.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = en && (count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Control FSM sequencing the fetch micro-steps on the shared bus:
//   T0 PCout/MARin/Inc, T1 Read/MDRin (waits on memory), T2 MDRout/IRin,
//   then EXEC until the execute controller reports done.
// Ports:
//   clock  in  system clock, rising edge
//   clear  in  asynchronous active-low reset
//   bus    fetch_sequencer_if.master: control inputs, strobes, exec_start,
//          halted, mem_fault, instr_count (retired instructions, wrapping)
// All outputs are registered decodes of the next state, so they change only
// on clock edges and cannot glitch.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    fetch_sequencer_if.master       bus
);

    fetchState_t      state;
    fetchState_t      nextState;
    strobes_t         strobeQ;
    strobes_t         strobeD;
    logic             execStartQ;
    logic             execStartD;
    logic             haltedQ;
    logic             faultQ;
    logic             retire;
    logic             timerClr;
    logic             timerEn;
    logic             timerExpired;
    logic [CNT_W-1:0] instrCount;

    assign timerClr = (state != T1);
    assign timerEn  = (state == T1);

    mem_wait_timer #(
        .TMR_W      (TMR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemWaitTimer (
        .clock  (clock),
        .clear  (clear),
        .clr    (timerClr),
        .en     (timerEn),
        .expired(timerExpired)
    );

    // State register. Reset aborts any fetch in progress immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic plus the decode of that next state into the output
    // values registered below. T0 only advances once its strobe cycle has
    // actually happened (strobeQ.pcOut), so a stall seen on entry or while
    // waiting keeps PC/MAR quiet and still yields exactly one increment.
    always_comb begin
        nextState  = state;
        retire     = 1'b0;
        strobeD    = NO_STROBES;
        execStartD = 1'b0;
        case (state)
            IDLE: begin
                if (bus.halt_req) begin
                    nextState = HALT;
                end else if (bus.run) begin
                    nextState = T0;
                end
            end
            T0: begin
                if (strobeQ.pcOut) begin
                    nextState = T1;
                end
            end
            T1: begin
                if (bus.mem_ready) begin
                    nextState = T2;
                end else if (timerExpired) begin
                    nextState = FAULT;
                end
            end
            T2: nextState = EXEC;
            EXEC: begin
                if (bus.exec_done) begin
                    retire = 1'b1;
                    if (bus.halt_req) begin
                        nextState = HALT;
                    end else if (bus.run) begin
                        nextState = T0;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            HALT:    nextState = HALT;
            FAULT:   nextState = FAULT;
            default: nextState = IDLE;
        endcase
        strobeD    = decodeStrobes(nextState, bus.stall);
        execStartD = (nextState == EXEC) && (state != EXEC);
    end

    // Output registers, loaded with the decode of the state being entered.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            strobeQ    <= NO_STROBES;
            execStartQ <= 1'b0;
            haltedQ    <= 1'b0;
            faultQ     <= 1'b0;
        end else begin
            strobeQ    <= strobeD;
            execStartQ <= execStartD;
            haltedQ    <= (nextState == HALT);
            faultQ     <= (nextState == FAULT);
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            instrCount <= '0;
        end else if (retire) begin
            instrCount <= instrCount + CNT_W'(1);
        end
    end

    assign bus.PCout       = strobeQ.pcOut;
    assign bus.MARin       = strobeQ.marIn;
    assign bus.Inc         = strobeQ.inc;
    assign bus.Read        = strobeQ.read;
    assign bus.MDRin       = strobeQ.mdrIn;
    assign bus.MDRout      = strobeQ.mdrOut;
    assign bus.IRin        = strobeQ.irIn;
    assign bus.exec_start  = execStartQ;
    assign bus.halted      = haltedQ;
    assign bus.mem_fault   = faultQ;
    assign bus.instr_count = instrCount;

    // The PC register and the MDR share the bus; never both driving it.
    singleBusDriver: assert property (@(posedge clock) disable iff (!clear)
        !(strobeQ.pcOut && strobeQ.mdrOut));

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer built with CNT_W=4 so the counter wrap
// is reachable. Outputs are sampled 1 time unit after each rising edge.
// Observed vector order: {PCout,MARin,Inc,Read,MDRin,MDRout,IRin,
//                         exec_start,halted,mem_fault}
module tb_fetch_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int TMR_W       = 4;

    localparam logic [9:0] V_NONE  = 10'b0000000000;
    localparam logic [9:0] V_T0    = 10'b1110000000;
    localparam logic [9:0] V_T1    = 10'b0001100000;
    localparam logic [9:0] V_T2    = 10'b0000011000;
    localparam logic [9:0] V_START = 10'b0000000100;
    localparam logic [9:0] V_HALT  = 10'b0000000010;
    localparam logic [9:0] V_FAULT = 10'b0000000001;

    logic clock = 1'b0;
    logic clear;
    int   testCount = 0;
    int   failCount = 0;

    fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    fetch_sequencer #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    // 10-unit clock period
    always #5 clock = ~clock;

    // Packs the single-bit outputs into one vector for comparison
    function automatic logic [9:0] observedVec();
        return {bus.PCout, bus.MARin, bus.Inc, bus.Read, bus.MDRin,
                bus.MDRout, bus.IRin, bus.exec_start, bus.halted, bus.mem_fault};
    endfunction

    // Drives all control inputs at once
    task automatic applyStimulus(input logic r, input logic s, input logic h,
                                 input logic m, input logic e);
        bus.run       = r;
        bus.stall     = s;
        bus.halt_req  = h;
        bus.mem_ready = m;
        bus.exec_done = e;
    endtask

    // Advances to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compares output vector and instr_count against hand-computed values
    task automatic checkOutput(input string tag, input logic [9:0] expVec,
                               input logic [CNT_W-1:0] expCount);
        logic [9:0]       obsVec;
        logic [CNT_W-1:0] obsCount;
        obsVec   = observedVec();
        obsCount = bus.instr_count;
        testCount++;
        assert (obsVec === expVec) else begin
            failCount++;
            $error("[TB] FAIL %s outputs: observed %b expected %b", tag, obsVec, expVec);
        end
        testCount++;
        assert (obsCount === expCount) else begin
            failCount++;
            $error("[TB] FAIL %s instr_count: observed %0d expected %0d", tag, obsCount, expCount);
        end
    endtask

    // Pulses reset between edges and checks the asynchronous clear
    task automatic pulseReset(input string tag);
        clear = 1'b0;
        #1;
        checkOutput(tag, V_NONE, 0);
        applyStimulus(0, 0, 0, 0, 0);
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        #12;
        checkOutput("reset", V_NONE, 0);
        clear = 1'b1;
        tick(); checkOutput("idle", V_NONE, 0);

        // Basic fetch with memory ready in the first T1 cycle
        applyStimulus(1, 0, 0, 1, 0);
        tick(); checkOutput("basic T0", V_T0, 0);
        tick(); checkOutput("basic T1", V_T1, 0);
        tick(); checkOutput("basic T2", V_T2, 0);
        tick(); checkOutput("basic exec_start", V_START, 0);
        tick(); checkOutput("basic exec hold", V_NONE, 0);
        applyStimulus(0, 0, 0, 1, 1);
        tick(); checkOutput("basic retire", V_NONE, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(); checkOutput("basic idle", V_NONE, 1);

        // Three wait cycles in T1; run dropped mid-fetch
        applyStimulus(1, 0, 0, 0, 0);
        tick(); checkOutput("wait T0", V_T0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(); checkOutput("wait T1 c1", V_T1, 1);
        tick(); checkOutput("wait T1 c2", V_T1, 1);
        tick(); checkOutput("wait T1 c3", V_T1, 1);
        applyStimulus(0, 0, 0, 1, 0);
        tick(); checkOutput("wait T2", V_T2, 1);
        applyStimulus(0, 0, 0, 0, 1);
        tick(); checkOutput("wait exec_start", V_START, 1);
        tick(); checkOutput("wait retire idle", V_NONE, 2);

        // Stall for two T0 cycles, then back-to-back instructions and halt
        applyStimulus(1, 1, 0, 1, 0);
        tick(); checkOutput("stall c1", V_NONE, 2);
        tick(); checkOutput("stall c2", V_NONE, 2);
        applyStimulus(1, 0, 0, 1, 0);
        tick(); checkOutput("stall release T0", V_T0, 2);
        tick(); checkOutput("stall T1", V_T1, 2);
        tick(); checkOutput("stall T2", V_T2, 2);
        applyStimulus(1, 0, 0, 1, 1);
        tick(); checkOutput("stall exec_start", V_START, 2);
        tick(); checkOutput("back-to-back T0", V_T0, 3);
        applyStimulus(1, 0, 0, 1, 0);
        tick(); checkOutput("b2b T1", V_T1, 3);
        tick(); checkOutput("b2b T2", V_T2, 3);
        tick(); checkOutput("b2b exec_start", V_START, 3);
        applyStimulus(1, 0, 1, 1, 0);
        tick(); checkOutput("halt req exec hold", V_NONE, 3);
        applyStimulus(1, 0, 1, 1, 1);
        tick(); checkOutput("halted", V_HALT, 4);
        applyStimulus(1, 0, 0, 1, 0);
        tick(); checkOutput("halt sticky", V_HALT, 4);
        pulseReset("reset from halt");

        // Reset in the middle of T1
        applyStimulus(1, 0, 0, 0, 0);
        tick(); checkOutput("midreset T0", V_T0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        tick(); checkOutput("midreset T1", V_T1, 0);
        pulseReset("reset mid-T1");
        tick(); checkOutput("idle after reset", V_NONE, 0);

        // Memory never answers: fault after MEM_TIMEOUT T1 cycles
        applyStimulus(1, 0, 0, 0, 0);
        tick(); checkOutput("timeout T0", V_T0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            tick(); checkOutput($sformatf("timeout T1 c%0d", k), V_T1, 0);
        end
        tick(); checkOutput("mem_fault", V_FAULT, 0);
        applyStimulus(1, 0, 0, 1, 1);
        tick(); checkOutput("fault sticky", V_FAULT, 0);
        pulseReset("reset from fault");

        // mem_ready in the final allowed T1 cycle beats the timeout
        applyStimulus(1, 0, 0, 0, 0);
        tick(); checkOutput("late T0", V_T0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            tick();
        end
        checkOutput("late T1 final cycle", V_T1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        tick(); checkOutput("late T2", V_T2, 0);
        applyStimulus(0, 0, 0, 0, 1);
        tick(); checkOutput("late exec_start", V_START, 0);
        tick(); checkOutput("late retire", V_NONE, 1);
        pulseReset("reset before wrap");

        // Retire 17 instructions at 4 cycles each; counter wraps at 16
        applyStimulus(1, 0, 0, 1, 1);
        repeat (64) tick();
        tick(); checkOutput("wrap after 16", V_T0, 0);
        repeat (3) tick();
        checkOutput("wrap 17th exec_start", V_START, 0);
        applyStimulus(0, 0, 0, 1, 1);
        tick(); checkOutput("wrap after 17", V_NONE, 1);

        // halt_req wins over run in IDLE
        applyStimulus(1, 0, 1, 0, 0);
        tick(); checkOutput("idle halt priority", V_HALT, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
